mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single data/instruction memory port between the instruction-fetch requester (I-port) and the memory-stage requester (D-port) of the pipelined CPU. It serialises requests onto one variable-latency memory bus using a req/ack handshake and returns read data and a one-cycle acknowledge to the winning requester. A bus watchdog terminates hung transactions. The pipeline uses each port's ack to release its stall.

## Interface
Parameters:
- TIMEOUT, default 255: max cycles to wait for mem_ack before abort; 0 disables watchdog.
- CNT_W, default 8: watchdog counter width; TIMEOUT must fit in CNT_W bits.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction read request; held until i_ack.
- i_addr  in  32  instruction byte address.
- i_rdata  out  32  instruction read data, valid when i_ack=1.
- i_ack  out  1  one-cycle completion pulse for I-port.
- d_req  in  1  data request; held until d_ack.
- d_wr  in  1  1=write, 0=read.
- d_sz  in  2  access size, codes as ACCESS_SZ_* in defs.v.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_rdata  out  32  read data, valid when d_ack=1 and d_wr=0.
- d_ack  out  1  one-cycle completion pulse for D-port.
- bus_err  out  1  one-cycle pulse together with i_ack/d_ack when a transaction was aborted by the watchdog.
- mem_req  out  1  request to memory, held until mem_ack or abort.
- mem_wr, mem_sz, mem_addr, mem_wdata  out  1/2/32/32  registered copy of the granted request; I-port grants drive mem_wr=0, mem_sz=ACCESS_SZ_WORD, mem_wdata=0.
- mem_ack  in  1  memory completion, may arrive any cycle mem_req=1.
- mem_rdata  in  32  read data, valid with mem_ack.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE: evaluate eligible requests. A port is eligible when its req=1 and its own ack output is 0 in that cycle; this prevents re-issue of a request the master is about to drop.
- IDLE grant: latch the winner's fields into the mem_* registers and set mem_req=1. Move to BUSY_I or BUSY_D. Clear the watchdog counter.
- Default priority: D-port wins when both ports are eligible, because the memory stage is older than the fetch.
- BUSY_x, mem_ack=1: latch mem_rdata into x_rdata. Pulse x_ack next cycle. Drop mem_req. Return to IDLE.
- BUSY_x, mem_ack=0: increment the counter. When the counter equals TIMEOUT (TIMEOUT≠0):
  - drop mem_req and return to IDLE;
  - pulse x_ack and bus_err next cycle, with x_rdata=0.
- mem_* fields stay stable for the whole BUSY state.
- A master changing its address while its req is pending is a protocol violation. The arbiter uses the value latched at grant.
- x_rdata holds its last value between acks.

## Timing
- Reset values: mem_req=0, mem_wr=0, mem_sz=ACCESS_SZ_WORD, mem_addr=0, mem_wdata=0, i_ack=d_ack=bus_err=0, i_rdata=d_rdata=0, state=IDLE, counter=0.
- Reset asserted mid-transaction aborts immediately. All outputs take their reset values. No ack is ever issued for the aborted request.
- Uncontended latency: req sampled at cycle 0, mem_req=1 in cycle 1. If mem_ack arrives in cycle 1, x_ack=1 in cycle 2. Minimum is 2 cycles; each extra memory wait cycle adds 1.
- IDLE cycle after completion is mandatory, so back-to-back grants are spaced ≥3 cycles apart (req→ack→next mem_req).
- mem_ack is ignored in IDLE.
- Watchdog abort occurs in the cycle where counter==TIMEOUT. The ack and err pulses follow one cycle later.

## Configuration
- ARB_ROUND_ROBIN_EN defined: priority alternates. A 1-bit last-grant register (reset to I) gives the other port priority when both are eligible. A lone requester always wins.
- ARB_ROUND_ROBIN_EN undefined: fixed D-over-I priority as described above; no last-grant register.

## Test plan
- Reset then lone I read: i_req=1, i_addr=0x100, mem_ack one cycle after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_wr=0, i_ack pulse at cycle 2 with i_rdata=0xDEADBEEF.
- Lone D write: d_wr=1, d_sz=ACCESS_SZ_BYTE, d_addr=0x2003, d_wdata=0x55, mem_ack after 3 wait cycles -> mem_* mirror the request, d_ack at cycle 5, no i_ack.
- Simultaneous i_req and d_req held, ack latency 0:
  - ARB_ROUND_ROBIN_EN undefined: D served first, then I.
  - ARB_ROUND_ROBIN_EN defined: first grant goes to D (last-grant reset to I); with both requests held continuously after each completion, grants alternate D, I, D, I.
- Watchdog: TIMEOUT=4, D read, never ack -> mem_req high 5 cycles, then d_ack=1, bus_err=1, d_rdata=0, state IDLE.
- Reset mid-BUSY_I: assert rst while mem_req=1 -> all outputs at reset values immediately; after release with i_req still high, a fresh grant follows the normal 2-cycle latency.
- No double-issue: master holds i_req high during the i_ack cycle -> no new mem_req in that cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single memory port between the instruction-fetch requester
// (I-port) and the memory-stage requester (D-port). Requests are serialised
// onto one variable-latency req/ack memory bus. The winning requester gets
// its read data and a one-cycle ack. A watchdog aborts transactions that
// never see mem_ack. An aborted transaction returns zero data, and bus_err
// pulses together with the ack.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, D-port wins over I-port
//   defined   : alternating priority driven by a 1-bit last-grant register
//               (reset value = I, so the first contended grant goes to D)
//
// Parameters
//   TIMEOUT : maximum BUSY cycles without mem_ack before abort (0 = off)
//   CNT_W   : watchdog counter width (TIMEOUT must fit)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_req/i_addr             instruction read request (held until i_ack)
//   i_rdata/i_ack            instruction read data, completion pulse
//   d_req/d_wr/d_sz/d_addr/d_wdata
//                            data request (held until d_ack)
//   d_rdata/d_ack            data read data, completion pulse
//   bus_err                  pulses with the ack of a watchdog-aborted access
//   mem_req/mem_wr/mem_sz/mem_addr/mem_wdata
//                            registered copy of the granted request
//   mem_ack/mem_rdata        memory completion and read data
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no transaction on the bus; arbitrate eligible requests
// BUSY_I  | I-port request on the bus, waiting for mem_ack/timeout
// BUSY_D  | D-port request on the bus, waiting for mem_ack/timeout
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   // instruction port
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   // data port
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [1:0]  d_sz,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   // status
   output logic        bus_err,
   // memory bus
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_sz,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] ACCESS_SZ_BYTE = 2'b00;
   localparam logic [1:0] ACCESS_SZ_HALF = 2'b01;
   localparam logic [1:0] ACCESS_SZ_WORD = 2'b10;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_BUSY_I = 2'd1;
   localparam logic [1:0] ST_BUSY_D = 2'd2;

   localparam logic             WD_EN  = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] WD_TC  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;

   logic             r_mem_req;
   logic             r_mem_wr;
   logic [1:0]       r_mem_sz;
   logic [31:0]      r_mem_addr;
   logic [31:0]      r_mem_wdata;

   logic [31:0]      r_i_rdata;
   logic [31:0]      r_d_rdata;
   logic             r_i_ack;
   logic             r_d_ack;
   logic             r_bus_err;

   logic             w_i_elig;
   logic             w_d_elig;
   logic             w_grant_i;
   logic             w_grant_d;
   logic             w_busy;
   logic             w_done;
   logic             w_abort;

   // A port whose ack is high this cycle is about to drop its request, so
   // its still-asserted req must not be granted a second time.
   assign w_i_elig = i_req & ~r_i_ack;
   assign w_d_elig = d_req & ~r_d_ack;

`ifdef ARB_ROUND_ROBIN_EN
   // 1 = last grant went to D, 0 = last grant went to I
   logic r_last_d;

   // Under contention the port that did not win last time goes first.
   assign w_grant_d = (r_state == ST_IDLE) & w_d_elig & (~w_i_elig | ~r_last_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_d <= 1'b0;
      end else if (w_grant_d) begin
         r_last_d <= 1'b1;
      end else if (w_grant_i) begin
         r_last_d <= 1'b0;
      end
   end
`else
   // The memory stage holds the older instruction, so D always wins.
   assign w_grant_d = (r_state == ST_IDLE) & w_d_elig;
`endif

   assign w_grant_i = (r_state == ST_IDLE) & w_i_elig & ~w_grant_d;

   assign w_busy  = (r_state == ST_BUSY_I) | (r_state == ST_BUSY_D);
   // A real completion takes precedence over a watchdog expiry in the
   // same cycle.
   assign w_done  = w_busy & mem_ack;
   assign w_abort = w_busy & ~mem_ack & WD_EN & (r_cnt == WD_TC);

   // -----------------------------------------------------------------------
   // State register
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant_d) begin
                  r_state <= ST_BUSY_D;
               end else if (w_grant_i) begin
                  r_state <= ST_BUSY_I;
               end
            end
            ST_BUSY_I,
            ST_BUSY_D: begin
               if (w_done || w_abort) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Watchdog counter: cleared at grant, counts BUSY cycles without ack
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_grant_d || w_grant_i) begin
         r_cnt <= '0;
      end else if (w_busy && !mem_ack && !w_abort) begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

   // -----------------------------------------------------------------------
   // Memory bus request registers; fields only change at grant so they
   // stay stable for the whole BUSY state.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_req   <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_sz    <= ACCESS_SZ_WORD;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else if (w_grant_d) begin
         r_mem_req   <= 1'b1;
         r_mem_wr    <= d_wr;
         r_mem_sz    <= d_sz;
         r_mem_addr  <= d_addr;
         r_mem_wdata <= d_wdata;
      end else if (w_grant_i) begin
         r_mem_req   <= 1'b1;
         r_mem_wr    <= 1'b0;
         r_mem_sz    <= ACCESS_SZ_WORD;
         r_mem_addr  <= i_addr;
         r_mem_wdata <= '0;
      end else if (w_done || w_abort) begin
         r_mem_req   <= 1'b0;
      end
   end

   // -----------------------------------------------------------------------
   // Completion: ack/err pulses and read data, one cycle after the bus ends
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_i_ack   <= 1'b0;
         r_d_ack   <= 1'b0;
         r_bus_err <= 1'b0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         r_i_ack   <= (w_done || w_abort) && (r_state == ST_BUSY_I);
         r_d_ack   <= (w_done || w_abort) && (r_state == ST_BUSY_D);
         r_bus_err <= w_abort;
         if (r_state == ST_BUSY_I) begin
            if (w_done) begin
               r_i_rdata <= mem_rdata;
            end else if (w_abort) begin
               r_i_rdata <= '0;
            end
         end
         if (r_state == ST_BUSY_D) begin
            if (w_done) begin
               r_d_rdata <= mem_rdata;
            end else if (w_abort) begin
               r_d_rdata <= '0;
            end
         end
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_wr    = r_mem_wr;
   assign mem_sz    = r_mem_sz;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign i_rdata   = r_i_rdata;
   assign d_rdata   = r_d_rdata;
   assign i_ack     = r_i_ack;
   assign d_ack     = r_d_ack;
   assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_rdata;
   logic        i_ack;
   logic        d_req = 1'b0;
   logic        d_wr = 1'b0;
   logic [1:0]  d_sz = SZ_WORD;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        bus_err;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_sz;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_wr(d_wr), .d_sz(d_sz), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
      .bus_err(bus_err),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_sz(mem_sz),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst mem_wr", 32'(mem_wr), 32'd0);
      chk("rst mem_sz", 32'(mem_sz), 32'(SZ_WORD));
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
      chk("rst i_ack", 32'(i_ack), 32'd0);
      chk("rst d_ack", 32'(d_ack), 32'd0);
      chk("rst bus_err", 32'(bus_err), 32'd0);
      chk("rst i_rdata", i_rdata, 32'h0);
      chk("rst d_rdata", d_rdata, 32'h0);
      rst = 1'b0;
      step();

      // lone I read, ack in first bus cycle
      i_req = 1'b1; i_addr = 32'h100;
      step();
      chk("I1 mem_req", 32'(mem_req), 32'd1);
      chk("I1 mem_addr", mem_addr, 32'h100);
      chk("I1 mem_wr", 32'(mem_wr), 32'd0);
      chk("I1 mem_sz", 32'(mem_sz), 32'(SZ_WORD));
      chk("I1 mem_wdata", mem_wdata, 32'h0);
      chk("I1 i_ack early", 32'(i_ack), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      step();
      chk("I1 i_ack", 32'(i_ack), 32'd1);
      chk("I1 i_rdata", i_rdata, 32'hDEADBEEF);
      chk("I1 bus_err", 32'(bus_err), 32'd0);
      chk("I1 d_ack", 32'(d_ack), 32'd0);
      chk("I1 mem_req drop", 32'(mem_req), 32'd0);
      // i_req still held during the ack cycle: must not be re-issued
      mem_ack = 1'b0;
      step();
      chk("I1 no double issue", 32'(mem_req), 32'd0);
      chk("I1 i_ack single", 32'(i_ack), 32'd0);
      // mem_ack while idle is ignored
      i_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
      step();
      mem_ack = 1'b0;
      step();
      chk("idle ack i_ack", 32'(i_ack), 32'd0);
      chk("idle ack d_ack", 32'(d_ack), 32'd0);
      chk("idle ack i_rdata", i_rdata, 32'hDEADBEEF);

      // lone D byte write, three wait cycles
      d_req = 1'b1; d_wr = 1'b1; d_sz = SZ_BYTE; d_addr = 32'h2003; d_wdata = 32'h55;
      step();
      chk("D1 mem_req", 32'(mem_req), 32'd1);
      chk("D1 mem_wr", 32'(mem_wr), 32'd1);
      chk("D1 mem_sz", 32'(mem_sz), 32'(SZ_BYTE));
      chk("D1 mem_addr", mem_addr, 32'h2003);
      chk("D1 mem_wdata", mem_wdata, 32'h55);
      step();
      step();
      chk("D1 mem_req wait", 32'(mem_req), 32'd1);
      chk("D1 mem_addr stable", mem_addr, 32'h2003);
      chk("D1 d_ack wait", 32'(d_ack), 32'd0);
      step();
      mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
      step();
      chk("D1 d_ack", 32'(d_ack), 32'd1);
      chk("D1 i_ack", 32'(i_ack), 32'd0);
      chk("D1 bus_err", 32'(bus_err), 32'd0);
      chk("D1 mem_req drop", 32'(mem_req), 32'd0);
      d_req = 1'b0; d_wr = 1'b0; d_sz = SZ_WORD; mem_ack = 1'b0;
      step();
      chk("D1 d_ack single", 32'(d_ack), 32'd0);

      // watchdog: D read never acked, TIMEOUT=4
      d_req = 1'b1; d_addr = 32'h500;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("WD mem_req c%0d", k), 32'(mem_req), 32'd1);
         chk($sformatf("WD d_ack c%0d", k), 32'(d_ack), 32'd0);
      end
      step();
      chk("WD d_ack", 32'(d_ack), 32'd1);
      chk("WD bus_err", 32'(bus_err), 32'd1);
      chk("WD d_rdata", d_rdata, 32'h0);
      chk("WD mem_req drop", 32'(mem_req), 32'd0);
      d_req = 1'b0;
      step();
      chk("WD d_ack single", 32'(d_ack), 32'd0);
      chk("WD bus_err single", 32'(bus_err), 32'd0);
      chk("WD idle", 32'(mem_req), 32'd0);

      // reset in the middle of BUSY_I
      i_req = 1'b1; i_addr = 32'h600;
      step();
      chk("RST busy mem_req", 32'(mem_req), 32'd1);
      chk("RST busy mem_addr", mem_addr, 32'h600);
      mem_ack = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("RST mem_req", 32'(mem_req), 32'd0);
      chk("RST mem_addr", mem_addr, 32'h0);
      chk("RST mem_sz", 32'(mem_sz), 32'(SZ_WORD));
      chk("RST i_rdata", i_rdata, 32'h0);
      chk("RST i_ack", 32'(i_ack), 32'd0);
      step();
      step();
      chk("RST no ack", 32'(i_ack), 32'd0);
      rst = 1'b0; mem_ack = 1'b0;
      step();
      chk("RST regrant mem_req", 32'(mem_req), 32'd1);
      chk("RST regrant mem_addr", mem_addr, 32'h600);
      chk("RST regrant i_ack", 32'(i_ack), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
      step();
      chk("RST regrant ack", 32'(i_ack), 32'd1);
      chk("RST regrant rdata", i_rdata, 32'hA5A5A5A5);
      i_req = 1'b0; mem_ack = 1'b0;
      step();

      // contention, both held, zero-wait memory: D, I, D
      i_req = 1'b1; i_addr = 32'h300;
      d_req = 1'b1; d_addr = 32'h400; d_wr = 1'b0;
      step();
      chk("C1 grant D", mem_addr, 32'h400);
      mem_ack = 1'b1; mem_rdata = 32'h11;
      step();
      chk("C1 d_ack", 32'(d_ack), 32'd1);
      chk("C1 d_rdata", d_rdata, 32'h11);
      chk("C1 i_ack", 32'(i_ack), 32'd0);
      mem_ack = 1'b0;
      step();
      chk("C2 mem_req", 32'(mem_req), 32'd1);
      chk("C2 grant I", mem_addr, 32'h300);
      mem_ack = 1'b1; mem_rdata = 32'h22;
      step();
      chk("C2 i_ack", 32'(i_ack), 32'd1);
      chk("C2 i_rdata", i_rdata, 32'h22);
      mem_ack = 1'b0;
      step();
      chk("C3 mem_req", 32'(mem_req), 32'd1);
      chk("C3 grant D", mem_addr, 32'h400);
      mem_ack = 1'b1; mem_rdata = 32'h33;
      step();
      chk("C3 d_ack", 32'(d_ack), 32'd1);
      chk("C3 d_rdata", d_rdata, 32'h33);
      i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
      step();
      chk("C idle", 32'(mem_req), 32'd0);

      // fresh simultaneous requests after a D grant
      i_req = 1'b1; i_addr = 32'h700;
      d_req = 1'b1; d_addr = 32'h800;
      step();
`ifdef ARB_ROUND_ROBIN_EN
      chk("C4 grant I (rr)", mem_addr, 32'h700);
      mem_ack = 1'b1; mem_rdata = 32'h44;
      step();
      chk("C4 i_ack (rr)", 32'(i_ack), 32'd1);
      chk("C4 d_ack (rr)", 32'(d_ack), 32'd0);
`else
      chk("C4 grant D (fixed)", mem_addr, 32'h800);
      mem_ack = 1'b1; mem_rdata = 32'h44;
      step();
      chk("C4 d_ack (fixed)", 32'(d_ack), 32'd1);
      chk("C4 i_ack (fixed)", 32'(i_ack), 32'd0);
`endif
      i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
      step();
      step();
      chk("end idle", 32'(mem_req), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
